// File: rtl/input_skew_pkg.sv
// Shared types and defaults for the input skew buffer: FSM states and the router lane vector.
package input_skew_pkg;

    localparam int DEFAULT_ROW_COUNT  = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef logic [DEFAULT_ROW_COUNT-1:0][DEFAULT_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying one array row's element and its valid bit.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic [DEPTH-1:0]            valid_r;
    logic [DEPTH-1:0][WIDTH-1:0] data_r;

    // Shift every cycle; invalid slots carry zero data so bubbles reach the array as zeros.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            valid_r[0] <= d_valid;
            data_r[0]  <= d_valid ? d_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign q_valid = valid_r[DEPTH-1];
    assign q_data  = data_r[DEPTH-1];

endmodule

// File: rtl/input_skew_buffer.sv
// Captures router vectors and staggers row r by r extra cycles for the systolic array's diagonal dataflow.
module input_skew_buffer
    import input_skew_pkg::*;
#(
    parameter int ROW_COUNT   = DEFAULT_ROW_COUNT,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_en,
    input  logic                                 i_reg_clear,
    input  logic                                 i_data_out_ready,
    output logic                                 o_data_out_en,
    input  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data,
    input  logic                                 i_valid,
    input  logic                                 i_last,
    output logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data,
    output logic [ROW_COUNT-1:0]                 o_valid,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [COUNT_WIDTH-1:0]               o_count,
    output logic                                 o_overrun
);

    localparam int DRAIN_W = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;

    state_t             state_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic               clear_s;
    logic               capture_s;

    assign clear_s   = i_rst | i_reg_clear;
    assign capture_s = (state_r == ST_STREAM) && i_valid;

    // Run-control FSM; every status output is registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (clear_s) begin
            state_r       <= ST_IDLE;
            drain_cnt_r   <= '0;
            o_count       <= '0;
            o_overrun     <= 1'b0;
            o_done        <= 1'b0;
            o_data_out_en <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // Vectors outside STREAM are dropped and flagged; the flag is sticky until cleared.
            if (i_valid && (state_r != ST_STREAM)) begin
                o_overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_en) begin
                        state_r <= ST_WAIT;
                        o_count <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_data_out_ready) begin
                        state_r       <= ST_STREAM;
                        o_data_out_en <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (i_valid) begin
                        o_count <= o_count + COUNT_WIDTH'(1);
                        if (i_last) begin
                            state_r       <= ST_DRAIN;
                            o_data_out_en <= 1'b0;
                            drain_cnt_r   <= DRAIN_W'(ROW_COUNT - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait until the deepest row has emitted the last vector.
                    if (drain_cnt_r == '0) begin
                        state_r <= ST_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    o_busy        <= 1'b0;
                    o_data_out_en <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROW_COUNT; r++) begin : g_row
        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (DATA_WIDTH)
        ) u_line (
            .clk     (i_clk),
            .clear   (clear_s),
            .d_valid (capture_s),
            .d_data  (i_data[r]),
            .q_valid (o_valid[r]),
            .q_data  (o_data[r])
        );
    end

endmodule
